alu_top: RTL and testbench



---
 rtl/alu_top.sv | 90 +++++++++
 tb/tb_alu_top.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/alu_top.sv
// Registered signed ALU: arithmetic, logic and shifter units plus a signed comparator.
// Latency 1 cycle; there is no handshake and every rising edge loads a new result.
module alu_top #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [3:0]   s,
  output logic [N-1:0] F,
  output logic         carryOut,
  output logic         Overflow,
  output logic         Zero,
  output logic         G,
  output logic         E,
  output logic         L
);

  logic [N-1:0] b_op;
  logic         c_in;
  logic [N:0]   sum;
  logic [N-1:0] f_nxt;
  logic         c_nxt;
  logic         v_nxt;

  // Every arithmetic function is one N+1-bit add of A, a chosen second operand and a carry-in.
  always_comb begin
    b_op = B;
    c_in = 1'b0;
    case (s[3:2])
      2'b00: begin b_op = B;          c_in = 1'b0; end
      2'b01: begin b_op = ~B;         c_in = 1'b1; end
      2'b10: begin b_op = '0;         c_in = 1'b1; end
      default: begin b_op = '1;       c_in = 1'b0; end
    endcase
    sum = {1'b0, A} + {1'b0, b_op} + {{N{1'b0}}, c_in};
  end

  always_comb begin
    f_nxt = sum[N-1:0];
    c_nxt = 1'b0;
    v_nxt = 1'b0;
    case (s[1:0])
      2'b01: begin
        case (s[3:2])
          2'b00:   f_nxt = A & B;
          2'b01:   f_nxt = A | B;
          2'b10:   f_nxt = A ^ B;
          default: f_nxt = ~A;
        endcase
      end
      2'b11: begin
        case (s[3:2])
          2'b00: begin f_nxt = {A[N-2:0], 1'b0};   c_nxt = A[N-1]; end
          2'b01: begin f_nxt = {1'b0, A[N-1:1]};   c_nxt = A[0];   end
          2'b10: begin f_nxt = {A[N-1], A[N-1:1]}; c_nxt = A[0];   end
          default: begin f_nxt = {A[N-2:0], A[N-1]}; c_nxt = A[N-1]; end
        endcase
      end
      default: begin
        // 00 and 10 are the same arithmetic unit.
        f_nxt = sum[N-1:0];
        c_nxt = sum[N];
        v_nxt = (A[N-1] == b_op[N-1]) && (sum[N-1] != A[N-1]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      F        <= '0;
      carryOut <= 1'b0;
      Overflow <= 1'b0;
      Zero     <= 1'b0;
      G        <= 1'b0;
      E        <= 1'b0;
      L        <= 1'b0;
    end else begin
      F        <= f_nxt;
      carryOut <= c_nxt;
      Overflow <= v_nxt;
      Zero     <= (f_nxt == '0);
      G        <= ($signed(A) > $signed(B));
      E        <= (A == B);
      L        <= ($signed(A) < $signed(B));
    end
  end

endmodule

// File: tb/tb_alu_top.sv
// Bench for alu_top: directed vectors with literal expectations plus a per-cycle model compare.
module tb_alu_top;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [3:0]   s;
  logic [N-1:0] F;
  logic         carryOut, Overflow, Zero, G, E, L;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_top #(.N(N)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .s(s),
    .F(F), .carryOut(carryOut), .Overflow(Overflow), .Zero(Zero),
    .G(G), .E(E), .L(L)
  );

  typedef struct packed {
    logic [7:0] f;
    logic c, v, z, g, e, l;
  } res_t;

  // Outputs are derived from integer arithmetic on the operand values.
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] op, input logic r);
    res_t o;
    int ua, ub, sa, sb, bu, bs, cin, usum, ssum;
    o = '0;
    if (r) return o;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op[1:0])
      2'b01: begin
        case (op[3:2])
          2'd0: o.f = a & b;
          2'd1: o.f = a | b;
          2'd2: o.f = a ^ b;
          default: o.f = ~a;
        endcase
      end
      2'b11: begin
        case (op[3:2])
          2'd0: begin o.f = 8'((ua * 2) % 256);           o.c = (ua >= 128);     end
          2'd1: begin o.f = 8'(ua / 2);                   o.c = ((ua % 2) == 1); end
          2'd2: begin o.f = 8'(sa >>> 1);                 o.c = ((ua % 2) == 1); end
          default: begin o.f = 8'((ua * 2) % 256 + ua / 128); o.c = (ua >= 128); end
        endcase
      end
      default: begin
        case (op[3:2])
          2'd0: begin bu = ub;       bs = sb;      cin = 0; end
          2'd1: begin bu = 255 - ub; bs = -sb - 1; cin = 1; end
          2'd2: begin bu = 0;        bs = 0;       cin = 1; end
          default: begin bu = 255;   bs = -1;      cin = 0; end
        endcase
        usum = ua + bu + cin;
        ssum = sa + bs + cin;
        o.f = 8'(usum % 256);
        o.c = (usum >= 256);
        o.v = (ssum > 127) || (ssum < -128);
      end
    endcase
    o.z = (o.f == 8'h00);
    o.g = (sa > sb);
    o.e = (ua == ub);
    o.l = (sa < sb);
    return o;
  endfunction

  task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {F,c,v,z,g,e,l}=%h_%b, expected %h_%b",
               nm, act[13:6], act[5:0], exp[13:6], exp[5:0]);
    end
  endtask

  res_t exp_r;
  logic exp_vld = 1'b0;

  always @(posedge clk) begin
    exp_r   <= model(A, B, s, rst);
    exp_vld <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_vld)
      chk("model", {F, carryOut, Overflow, Zero, G, E, L}, exp_r);
  end

  task automatic drive(input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic r);
    A = a; B = b; s = op; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] f,
                     input logic c, input logic v, input logic z,
                     input logic g, input logic e, input logic l);
    chk(nm, {F, carryOut, Overflow, Zero, G, E, L}, {f, c, v, z, g, e, l});
  endtask

  logic [7:0] corners [8] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hFE, 8'h55, 8'hAA};

  initial begin
    drive(8'h00, 8'h00, 4'b0000, 1'b1);
    lit("reset0", 8'h00, 0, 0, 0, 0, 0, 0);

    drive(8'h7F, 8'h01, 4'b0000, 1'b0);
    lit("add_ovf", 8'h80, 0, 1, 0, 1, 0, 0);

    drive(8'h80, 8'h80, 4'b1100, 1'b1);
    lit("reset_mid", 8'h00, 0, 0, 0, 0, 0, 0);

    drive(8'h80, 8'h80, 4'b0100, 1'b0);
    lit("sub_eq", 8'h00, 1, 0, 1, 0, 1, 0);
    drive(8'h00, 8'h01, 4'b0100, 1'b0);
    lit("sub_borrow", 8'hFF, 0, 0, 0, 0, 0, 1);

    drive(8'hFF, 8'h00, 4'b1000, 1'b0);
    lit("inc_wrap", 8'h00, 1, 0, 1, 0, 0, 1);
    drive(8'h80, 8'h00, 4'b1100, 1'b0);
    lit("dec_wrap", 8'h7F, 1, 1, 0, 0, 0, 1);
    drive(8'hFF, 8'h00, 4'b1010, 1'b0);
    lit("inc_mirror", 8'h00, 1, 0, 1, 0, 0, 1);
    drive(8'h80, 8'h00, 4'b1110, 1'b0);
    lit("dec_mirror", 8'h7F, 1, 1, 0, 0, 0, 1);

    drive(8'hF0, 8'h3C, 4'b0001, 1'b0);
    lit("and", 8'h30, 0, 0, 0, 0, 0, 1);
    drive(8'hF0, 8'h3C, 4'b0101, 1'b0);
    lit("or", 8'hFC, 0, 0, 0, 0, 0, 1);
    drive(8'hF0, 8'h3C, 4'b1001, 1'b0);
    lit("xor", 8'hCC, 0, 0, 0, 0, 0, 1);
    drive(8'hF0, 8'h3C, 4'b1101, 1'b0);
    lit("not", 8'h0F, 0, 0, 0, 0, 0, 1);

    drive(8'h81, 8'h00, 4'b0011, 1'b0);
    lit("lsl", 8'h02, 1, 0, 0, 0, 0, 1);
    drive(8'h81, 8'h00, 4'b0111, 1'b0);
    lit("lsr", 8'h40, 1, 0, 0, 0, 0, 1);
    drive(8'h81, 8'h00, 4'b1011, 1'b0);
    lit("asr", 8'hC0, 1, 0, 0, 0, 0, 1);
    drive(8'h81, 8'h00, 4'b1111, 1'b0);
    lit("rol", 8'h03, 1, 0, 0, 0, 0, 1);
    drive(8'h80, 8'h00, 4'b0011, 1'b0);
    lit("lsl_zero", 8'h00, 1, 0, 1, 0, 0, 1);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        for (int op = 0; op < 16; op++)
          drive(corners[i], corners[j], 4'(op), 1'b0);

    for (int k = 0; k < 3000; k++)
      drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            4'($urandom_range(0, 15)), 1'b0);

    drive(8'h7F, 8'h01, 4'b0000, 1'b0);
    drive(8'h7F, 8'h01, 4'b0000, 1'b1);
    lit("reset_end", 8'h00, 0, 0, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
